// File: rtl/obi_mem_responder.sv
// obi_mem_responder
// Memory-side responder for an OBI-style request/grant/rvalid interface. It
// backs a single-port, word-addressed SRAM with a fixed response latency and
// a bounded number of outstanding (granted but not yet answered) requests.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous reset, active-high
//   req_i     request valid; held with its fields until granted
//   gnt_o     grant (combinational); accepted on the edge with req_i && gnt_o
//   addr_i    byte address, bits [1:0] ignored
//   we_i      1 = write, 0 = read
//   be_i      write byte enables
//   wdata_i   write data
//   rvalid_o  response valid, exactly Latency cycles after the grant edge
//   rdata_o   read data (0 for writes, errors and idle cycles)
//   err_o     address out of range (0 on idle cycles)
//
// Optional feature: define RESP_STALL_EN to suppress roughly a quarter of the
// grant cycles with a 16-bit LFSR seeded from StallSeed.
module obi_mem_responder #(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter int unsigned          NumWords       = 1024,
    parameter logic [AddrWidth-1:0] BaseAddr       = '0,
    parameter int unsigned          Latency        = 1,
    parameter int unsigned          MaxOutstanding = 2,
    parameter logic [15:0]          StallSeed      = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   rvalid_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   err_o
);

    localparam int unsigned NumBytes = DataWidth / 8;
    localparam int unsigned IdxWidth = $clog2(NumWords);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    // One extra bit so a window covering the whole address space still fits.
    localparam logic [AddrWidth:0] SpanBytes = (AddrWidth + 1)'(NumWords * NumBytes);

    typedef struct packed {
        logic                 vld;
        logic [DataWidth-1:0] data;
        logic                 err;
    } resp_t;

    logic [DataWidth-1:0] mem [NumWords];
    resp_t                resp_pipe [Latency];
    resp_t                resp_in;
    logic [CntWidth-1:0]  outstanding;
    logic [CntWidth:0]    occupancy;
    logic [AddrWidth-1:0] offset;
    logic [IdxWidth-1:0]  idx;
    logic                 in_range;
    logic                 stall;

    // Wrapping subtraction keeps addresses below BaseAddr out of range.
    assign offset   = addr_i - BaseAddr;
    assign in_range = {1'b0, offset} < SpanBytes;
    assign idx      = offset[IdxWidth+1:2];

`ifdef RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr <= StallSeed;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    logic unused_seed;
    assign unused_seed = ^StallSeed;
    assign stall       = 1'b0;
`endif

    // A response leaving this cycle frees its slot immediately, so grants
    // resume in the same cycle the pipeline drains.
    assign occupancy = {1'b0, outstanding} - (CntWidth + 1)'(rvalid_o);
    assign gnt_o     = req_i && !rst_i && !stall
                       && (occupancy < (CntWidth + 1)'(MaxOutstanding));

    always_comb begin
        resp_in      = '0;
        resp_in.vld  = gnt_o;
        resp_in.err  = gnt_o && !in_range;
        if (gnt_o && !we_i && in_range) resp_in.data = mem[idx];
    end

    // No reset on the array: contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be_i[b]) mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < Latency; s++) resp_pipe[s] <= '0;
        end else begin
            resp_pipe[0] <= resp_in;
            for (int s = 1; s < Latency; s++) resp_pipe[s] <= resp_pipe[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else begin
            case ({gnt_o, rvalid_o})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign rvalid_o = resp_pipe[Latency-1].vld;
    assign rdata_o  = resp_pipe[Latency-1].data;
    assign err_o    = resp_pipe[Latency-1].err;

`ifndef SYNTHESIS
    // Simulation-only checks: counter bounds and request stability.
    logic                   held_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   we_q;
    logic [DataWidth/8-1:0] be_q;
    logic [DataWidth-1:0]   wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q <= 1'b0;
        end else begin
            held_q <= req_i && !gnt_o;
        end
        addr_q  <= addr_i;
        we_q    <= we_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
        if (!rst_i) begin
            assert (outstanding <= CntWidth'(MaxOutstanding));
            assert (!(rvalid_o && outstanding == '0));
            if (held_q) begin
                assert (req_i && addr_i == addr_q && we_i == we_q
                        && be_i == be_q && wdata_i == wdata_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: two instances (Latency 1 and 3, both with two
// outstanding) checked every cycle against a transaction-level model (a word
// array plus a queue of responses tagged with their due cycle), with directed
// scenarios pinning hand-computed values and a randomized traffic phase.
module tb_obi_mem_responder;

    localparam int NI = 2;
    localparam int MO = 2;
    localparam int LAT [NI] = '{1, 3};

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_s    [NI];
    logic        gnt_s    [NI];
    logic [31:0] addr_s   [NI];
    logic        we_s     [NI];
    logic [3:0]  be_s     [NI];
    logic [31:0] wdata_s  [NI];
    logic        rvalid_s [NI];
    logic [31:0] rdata_s  [NI];
    logic        err_s    [NI];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [NI][1024];
    exp_t        rq [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        obi_mem_responder #(
            .AddrWidth(32), .DataWidth(32), .NumWords(1024), .BaseAddr(32'h0),
            .Latency(g == 0 ? 1 : 3), .MaxOutstanding(MO), .StallSeed(16'hACE1)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .req_i(req_s[g]), .gnt_o(gnt_s[g]),
            .addr_i(addr_s[g]), .we_i(we_s[g]), .be_i(be_s[g]), .wdata_i(wdata_s[g]),
            .rvalid_o(rvalid_s[g]), .rdata_o(rdata_s[g]), .err_o(err_s[g])
        );
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endfunction

    // Reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic        fr, allowed, inr;
        logic [31:0] off, d;
        logic [9:0]  wi;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                chk($sformatf("gnt_in_reset[%0d]", i), 32'(gnt_s[i]), 0);
                rq[i].delete();
            end else begin
                fr = rq[i].size() > 0 && rq[i][0].due == cyc;
                chk($sformatf("rvalid[%0d]", i), 32'(rvalid_s[i]), 32'(fr));
                chk($sformatf("rdata[%0d]", i), rdata_s[i], fr ? rq[i][0].d : 32'h0);
                chk($sformatf("err[%0d]", i), 32'(err_s[i]), fr ? 32'(rq[i][0].e) : 0);
                allowed = req_s[i] && (rq[i].size() - int'(fr)) < MO;
`ifdef RESP_STALL_EN
                chk($sformatf("gnt_illegal[%0d]", i), 32'(gnt_s[i] && !allowed), 0);
`else
                chk($sformatf("gnt[%0d]", i), 32'(gnt_s[i]), 32'(allowed));
`endif
                if (fr) void'(rq[i].pop_front());
                if (req_s[i] && gnt_s[i]) begin
                    off = addr_s[i] - 32'h0;
                    inr = off < 32'h1000;
                    wi  = off[11:2];
                    d   = 32'h0;
                    if (we_s[i]) begin
                        if (inr) begin
                            for (int b = 0; b < 4; b++)
                                if (be_s[i][b]) mem_m[i][wi][b*8 +: 8] = wdata_s[i][b*8 +: 8];
                        end
                    end else if (inr) begin
                        d = mem_m[i][wi];
                    end
                    rq[i].push_back('{cyc + LAT[i], d, !inr});
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, output int gc);
        int n;
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; be_s[i] = b; wdata_s[i] = d;
        gc = -1;
        n  = 0;
        while (gc < 0 && n < 100) begin
            @(negedge clk);
            if (gnt_s[i]) gc = cyc;
            n++;
        end
        if (gc < 0) begin
            checks++; errors++;
            $display("FAIL issue_timeout[%0d]: no grant in 100 cycles, want grant", i);
        end
        @(posedge clk); #1;
        req_s[i] = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int i, input logic [31:0] ed,
                             input logic ee, output int rc);
        int n;
        rc = -1;
        n  = 0;
        while (rc < 0 && n < 50) begin
            @(negedge clk);
            if (rvalid_s[i]) begin
                rc = cyc;
                chk({name, "_rdata"}, rdata_s[i], ed);
                chk({name, "_err"}, 32'(err_s[i]), 32'(ee));
            end
            n++;
        end
        if (rc < 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no rvalid in 50 cycles, want rvalid", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_run(input int i, input int count);
        int          gc, r;
        logic [31:0] a;
        for (int k = 0; k < count; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 15)) * 4;
            else if (r < 9) a = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            else            a = 32'hFFFF_FFF0;
            a[1:0] = 2'($urandom_range(0, 3));
            issue(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, gc);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
    endtask

    initial begin
        int gw, gr, rc, g0, g1, g2, g3;
        for (int i = 0; i < NI; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; be_s[i] = '0; wdata_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_gnt[%0d]", i), 32'(gnt_s[i]), 0);
            chk($sformatf("reset_rvalid[%0d]", i), 32'(rvalid_s[i]), 0);
            chk($sformatf("reset_rdata[%0d]", i), rdata_s[i], 0);
            chk($sformatf("reset_err[%0d]", i), 32'(err_s[i]), 0);
        end
        @(posedge clk); #1;

        // Known contents for the words the bench touches.
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 16; k++)
                issue(i, 1'b1, 32'(k * 4), 4'hF, 32'hA5A5_0000 + 32'(k), gw);
        idle(5);

        // Write then read the same word on the next cycle, Latency 1.
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, gw);
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, gr);
        chk("t1_read_grant_cycle", 32'(gr), 32'(gw + 1));
        wait_resp("t1", 0, 32'hDEAD_BEEF, 1'b0, rc);
        chk("t1_resp_cycle", 32'(rc), 32'(gr + 1));

        // Partial byte-enable write.
        issue(0, 1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, gw);
        issue(0, 1'b1, 32'h14, 4'b0101, 32'h1122_3344, gw);
        issue(0, 1'b0, 32'h14, 4'h0, 32'h0, gr);
        wait_resp("t2", 0, 32'hFF22_FF44, 1'b0, rc);

        // Out of range: error read, and a write that must not alias word 0.
        issue(0, 1'b0, 32'h1000, 4'h0, 32'h0, gr);
        wait_resp("t4_oor_read", 0, 32'h0, 1'b1, rc);
        issue(0, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, gw);
        issue(0, 1'b0, 32'h0, 4'h0, 32'h0, gr);
        wait_resp("t4_word0", 0, 32'hA5A5_0000, 1'b0, rc);
        idle(3);

        // Latency 3 with two outstanding: third grant waits for first response.
        issue(1, 1'b0, 32'h0, 4'h0, 32'h0, g0);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, g1);
        issue(1, 1'b0, 32'h8, 4'h0, 32'h0, g2);
        issue(1, 1'b0, 32'hC, 4'h0, 32'h0, g3);
        chk("t3_grant1", 32'(g1 - g0), 1);
        chk("t3_grant2", 32'(g2 - g0), 3);
        chk("t3_grant3", 32'(g3 - g0), 4);
        idle(6);

        // Reset with two responses in flight.
        issue(1, 1'b0, 32'h0, 4'h0, 32'h0, g0);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, g1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_after_reset", 32'(rvalid_s[1]), 0);
        @(posedge clk); #1;
        gw = cyc;
        issue(1, 1'b0, 32'h8, 4'h0, 32'h0, gr);
        chk("t5_post_reset_grant", 32'(gr), 32'(gw));
        wait_resp("t5_read", 1, 32'hA5A5_0002, 1'b0, rc);
        idle(3);

        // Randomized traffic on both instances.
        fork
            rand_run(0, 500);
            rand_run(1, 500);
        join
        idle(10);
        for (int i = 0; i < NI; i++)
            chk($sformatf("drained[%0d]", i), 32'(rq[i].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
